// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared definitions for the alarm ring controller: state encoding and
// default timing constants.
package alarm_ring_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_time_match_cmp.sv
// Combinational equality of the current time against the stored alarm time,
// digit by digit in BCD.
module time_match_cmp (
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  input  logic [3:0] alarm_ms_hr,
  input  logic [3:0] alarm_ls_hr,
  input  logic [3:0] alarm_ms_min,
  input  logic [3:0] alarm_ls_min,
  output logic       match
);

  assign match = (cur_ms_hr  == alarm_ms_hr)  &&
                 (cur_ls_hr  == alarm_ls_hr)  &&
                 (cur_ms_min == alarm_ms_min) &&
                 (cur_ls_min == alarm_ls_min);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: fires once on the rising edge of a time match, rings
// for RING_SEC seconds, and supports up to MAX_SNOOZE snoozes per event.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_en,
  input  logic       sec_tick,
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  input  logic       stop_alarm,
  input  logic       snooze,
  output logic       sound_alarm,
  output logic       snoozing,
  output logic [1:0] snooze_left
);

  localparam int CNT_W = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       SNZ_LD    = 2'(MAX_SNOOZE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       snooze_left_q, snooze_left_d;
  logic             match, match_q;
  logic             sound_alarm_q, snoozing_q;
  logic             trigger;

  time_match_cmp u_cmp (
    .cur_ms_hr    (cur_ms_hr),
    .cur_ls_hr    (cur_ls_hr),
    .cur_ms_min   (cur_ms_min),
    .cur_ls_min   (cur_ls_min),
    .alarm_ms_hr  (alarm_time_ms_hr),
    .alarm_ls_hr  (alarm_time_ls_hr),
    .alarm_ms_min (alarm_time_ms_min),
    .alarm_ls_min (alarm_time_ls_min),
    .match        (match)
  );

  assign trigger = alarm_en & match & ~match_q;

  always_comb begin
    state_d       = state_q;
    sec_cnt_d     = sec_cnt_q;
    snooze_left_d = snooze_left_q;
    if (!alarm_en) begin
      state_d       = ST_IDLE;
      sec_cnt_d     = '0;
      snooze_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d       = ST_RINGING;
            sec_cnt_d     = RING_LD;
            snooze_left_d = SNZ_LD;
          end
        end
        ST_RINGING: begin
          if (stop_alarm) begin
            state_d       = ST_IDLE;
            sec_cnt_d     = '0;
            snooze_left_d = '0;
          end else if (snooze && (snooze_left_q != 2'd0)) begin
            state_d       = ST_SNOOZE;
            sec_cnt_d     = SNOOZE_LD;
            snooze_left_d = snooze_left_q - 2'd1;
          end else if (sec_tick) begin
            if (sec_cnt_q <= CNT_ONE) begin
              state_d       = ST_IDLE;
              sec_cnt_d     = '0;
              snooze_left_d = '0;
            end else begin
              sec_cnt_d = sec_cnt_q - CNT_ONE;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_alarm) begin
            state_d       = ST_IDLE;
            sec_cnt_d     = '0;
            snooze_left_d = '0;
          end else if (sec_tick) begin
            if (sec_cnt_q <= CNT_ONE) begin
              state_d   = ST_RINGING;
              sec_cnt_d = RING_LD;
            end else begin
              sec_cnt_d = sec_cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d       = ST_IDLE;
          sec_cnt_d     = '0;
          snooze_left_d = '0;
        end
      endcase
    end
  end

  // match_q resets high so a time already matching at reset release cannot fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sec_cnt_q     <= '0;
      snooze_left_q <= '0;
      match_q       <= 1'b1;
      sound_alarm_q <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      snooze_left_q <= snooze_left_d;
      match_q       <= match;
      sound_alarm_q <= (state_d == ST_RINGING);
      snoozing_q    <= (state_d == ST_SNOOZE);
    end
  end

  assign sound_alarm = sound_alarm_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl with a minute-level behavioural model
// and directed scenarios.
module tb_alarm_ring_ctrl;

  localparam int P_RING   = 4;
  localparam int P_SNOOZE = 3;
  localparam int P_MAXSNZ = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alarm_en = 1'b1;
  logic       sec_tick = 1'b0;
  logic       stop_alarm = 1'b0;
  logic       snooze = 1'b0;
  logic [3:0] c_mh = 4'd0, c_lh = 4'd7, c_mm = 4'd2, c_lm = 4'd9;
  logic [3:0] a_mh = 4'd0, a_lh = 4'd7, a_mm = 4'd3, a_lm = 4'd0;
  logic       sound_alarm, snoozing;
  logic [1:0] snooze_left;

  int checks = 0;
  int failures = 0;

  alarm_ring_ctrl #(
    .RING_SEC   (P_RING),
    .SNOOZE_SEC (P_SNOOZE),
    .MAX_SNOOZE (P_MAXSNZ)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .alarm_en          (alarm_en),
    .sec_tick          (sec_tick),
    .cur_ms_hr         (c_mh),
    .cur_ls_hr         (c_lh),
    .cur_ms_min        (c_mm),
    .cur_ls_min        (c_lm),
    .alarm_time_ms_hr  (a_mh),
    .alarm_time_ls_hr  (a_lh),
    .alarm_time_ms_min (a_mm),
    .alarm_time_ls_min (a_lm),
    .stop_alarm        (stop_alarm),
    .snooze            (snooze),
    .sound_alarm       (sound_alarm),
    .snoozing          (snoozing),
    .snooze_left       (snooze_left)
  );

  always #5 clk = ~clk;

  function automatic int minutes_of(input logic [3:0] mh, input logic [3:0] lh,
                                    input logic [3:0] mm, input logic [3:0] lm);
    return (int'(mh) * 10 + int'(lh)) * 60 + int'(mm) * 10 + int'(lm);
  endfunction

  // Model: mode 0 = quiet, 1 = ringing, 2 = snoozed; remaining seconds and snoozes.
  int m_mode = 0, m_remain = 0, m_left = 0;
  bit m_prev_match = 1'b1;

  always @(posedge clk or negedge reset) begin
    bit now_match, fire;
    if (!reset) begin
      m_mode = 0; m_remain = 0; m_left = 0; m_prev_match = 1'b1;
    end else begin
      now_match = (minutes_of(c_mh, c_lh, c_mm, c_lm) == minutes_of(a_mh, a_lh, a_mm, a_lm));
      fire = alarm_en && now_match && !m_prev_match;
      m_prev_match = now_match;
      if (!alarm_en) begin
        m_mode = 0; m_left = 0;
      end else if (m_mode == 0) begin
        if (fire) begin m_mode = 1; m_remain = P_RING; m_left = P_MAXSNZ; end
      end else if (stop_alarm) begin
        m_mode = 0; m_left = 0;
      end else if (m_mode == 1 && snooze && m_left > 0) begin
        m_mode = 2; m_remain = P_SNOOZE; m_left = m_left - 1;
      end else if (sec_tick) begin
        m_remain = m_remain - 1;
        if (m_remain <= 0) begin
          if (m_mode == 1) begin m_mode = 0; m_left = 0; end
          else begin m_mode = 1; m_remain = P_RING; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (sound_alarm !== (m_mode == 1) || snoozing !== (m_mode == 2) ||
          int'(snooze_left) != m_left) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual sound=%0b snz=%0b left=%0d expected sound=%0b snz=%0b left=%0d",
                 $time, sound_alarm, snoozing, snooze_left, (m_mode == 1), (m_mode == 2), m_left);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic tick();
    sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
  endtask

  task automatic snooze_p();
    snooze = 1'b1; cyc(); snooze = 1'b0;
  endtask

  task automatic set_cur(input int mh, input int lh, input int mm, input int lm);
    c_mh = 4'(mh); c_lh = 4'(lh); c_mm = 4'(mm); c_lm = 4'(lm);
  endtask

  task automatic set_alarm(input int mh, input int lh, input int mm, input int lm);
    a_mh = 4'(mh); a_lh = 4'(lh); a_mm = 4'(mm); a_lm = 4'(lm);
  endtask

  task automatic fresh_ring();
    set_cur(0, 7, 2, 9); cyc();
    set_alarm(0, 7, 3, 0); cyc();
    set_cur(0, 7, 3, 0); cyc();
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_sound", int'(sound_alarm), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    chk("rst_left", int'(snooze_left), 0);
    reset = 1'b1;
    repeat (2) cyc();

    // Basic fire and auto-stop after RING_SEC ticks
    set_cur(0, 7, 3, 0); cyc();
    chk("fire_sound", int'(sound_alarm), 1);
    chk("fire_left", int'(snooze_left), 2);
    repeat (3) tick();
    chk("ring_3ticks", int'(sound_alarm), 1);
    tick();
    chk("ring_expire", int'(sound_alarm), 0);
    chk("expire_left", int'(snooze_left), 0);
    repeat (5) cyc();
    chk("no_refire", int'(sound_alarm), 0);

    // Each digit must match
    set_alarm(1, 7, 3, 0); set_cur(0, 7, 2, 9); cyc();
    set_cur(0, 7, 3, 0); repeat (2) cyc();
    chk("hr_digit_differs", int'(sound_alarm), 0);
    set_alarm(0, 7, 3, 1); repeat (2) cyc();
    chk("min_digit_differs", int'(sound_alarm), 0);

    // Snooze sequence, exhaustion, then auto-stop
    fresh_ring();
    chk("s_ring", int'(sound_alarm), 1);
    snooze_p();
    chk("s1_snoozing", int'(snoozing), 1);
    chk("s1_left", int'(snooze_left), 1);
    repeat (2) tick();
    chk("s1_still_snz", int'(snoozing), 1);
    tick();
    chk("s1_rering", int'(sound_alarm), 1);
    snooze_p();
    chk("s2_left", int'(snooze_left), 0);
    chk("s2_snoozing", int'(snoozing), 1);
    repeat (3) tick();
    chk("s2_rering", int'(sound_alarm), 1);
    snooze_p();
    chk("s3_ignored", int'(snoozing), 0);
    repeat (3) tick();
    chk("s3_still_ring", int'(sound_alarm), 1);
    tick();
    chk("s3_expire", int'(sound_alarm), 0);

    // sec_tick in the trigger clock is not counted
    set_cur(0, 7, 2, 9); cyc();
    set_cur(0, 7, 3, 0); sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
    chk("trig_tick_fire", int'(sound_alarm), 1);
    repeat (3) tick();
    chk("trig_tick_ring", int'(sound_alarm), 1);
    tick();
    chk("trig_tick_end", int'(sound_alarm), 0);

    // stop beats snooze
    fresh_ring();
    stop_alarm = 1'b1; snooze = 1'b1; cyc(); stop_alarm = 1'b0; snooze = 1'b0;
    chk("stop_snz_sound", int'(sound_alarm), 0);
    chk("stop_snz_snoozing", int'(snoozing), 0);

    // stop during snooze
    fresh_ring(); snooze_p();
    stop_alarm = 1'b1; cyc(); stop_alarm = 1'b0;
    chk("snz_stop", int'(snoozing), 0);
    chk("snz_stop_left", int'(snooze_left), 0);

    // alarm_en drop during snooze, re-enable during the match minute
    fresh_ring(); snooze_p();
    alarm_en = 1'b0; cyc();
    chk("en_off_snz", int'(snoozing), 0);
    chk("en_off_left", int'(snooze_left), 0);
    alarm_en = 1'b1; repeat (4) cyc();
    chk("en_on_nofire", int'(sound_alarm), 0);

    // Async reset mid-ring
    fresh_ring();
    chk("r_ring", int'(sound_alarm), 1);
    #1 reset = 1'b0;
    #1;
    chk("r_async_sound", int'(sound_alarm), 0);
    chk("r_async_left", int'(snooze_left), 0);
    cyc(); reset = 1'b1;
    repeat (4) cyc();
    chk("r_release_nofire", int'(sound_alarm), 0);
    set_cur(0, 7, 3, 1); cyc();
    set_cur(0, 7, 3, 0); cyc();
    chk("r_next_fire", int'(sound_alarm), 1);
    chk("r_next_left", int'(snooze_left), 2);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
